// File: rtl/rs_call_sequencer_if.sv
// Command, redirect and return-stack signals of the call sequencer.
// master = decode stage plus attached stack, slave = sequencer.
interface rs_call_sequencer_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DW    = 7
) ();

  logic             cmd_valid;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_target;
  logic [WIDTH-1:0] cur_pc;
  logic             cmd_ready;

  logic             pc_load;
  logic [WIDTH-1:0] pc_next;

  logic [1:0]       stack_op;
  logic [WIDTH-1:0] stack_w;
  logic [WIDTH-1:0] stack_a;

  logic [DW-1:0]    depth;
  logic             overflow;
  logic             underflow;
  logic             busy;

  modport master (
    output cmd_valid, cmd_op, cmd_target, cur_pc, stack_a,
    input  cmd_ready, pc_load, pc_next, stack_op, stack_w, depth, overflow, underflow, busy
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_target, cur_pc, stack_a,
    output cmd_ready, pc_load, pc_next, stack_op, stack_w, depth, overflow, underflow, busy
  );

endinterface

// File: rtl/rs_call_sequencer.sv
// Return-stack call sequencer: maps call/ret/flush commands onto stack push/pop
// operations and PC redirects, tracking occupancy and sticky overflow/underflow.
module rs_call_sequencer #(
  parameter int unsigned      DEPTH     = 64,
  parameter int unsigned      WIDTH     = 16,
  parameter int unsigned      DW        = 7,
  parameter int unsigned      PC_STEP   = 1,
  parameter logic [WIDTH-1:0] TRAP_ADDR = '0
) (
  input logic                clk,
  input logic                reset,
  rs_call_sequencer_if.slave bus
);

  localparam logic [1:0] OpNop   = 2'b00;
  localparam logic [1:0] OpCall  = 2'b01;
  localparam logic [1:0] OpRet   = 2'b10;
  localparam logic [1:0] OpFlush = 2'b11;

  localparam logic [1:0] StackNop  = 2'b00;
  localparam logic [1:0] StackPush = 2'b01;
  localparam logic [1:0] StackPop  = 2'b11;

  typedef enum logic [0:0] {
    StIdle,
    StFlush
  } state_e;

  state_e           state_q, state_d;

  logic [1:0]       stack_op_q, stack_op_d;
  logic [WIDTH-1:0] stack_w_q, stack_w_d;
  logic             pc_load_q, pc_load_d;
  logic [WIDTH-1:0] pc_next_q, pc_next_d;
  logic [DW-1:0]    depth_q, depth_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             busy_q, busy_d;

  logic cmd_ready;
  logic accept;
  logic full;
  logic empty;
  logic last_pop;

  assign cmd_ready = (state_q == StIdle) && !reset;
  assign accept    = bus.cmd_valid && cmd_ready && (bus.cmd_op != OpNop);
  assign full      = (depth_q == DW'(DEPTH));
  assign empty     = (depth_q == '0);
  // Flush never runs with depth 0, so depth 1 marks the final pop.
  assign last_pop  = (depth_q <= DW'(1));

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (accept && (bus.cmd_op == OpFlush) && !empty) begin
          state_d = StFlush;
        end
      end
      StFlush: begin
        if (last_pop) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output next-values; stack_op and pc_load fall back to zero every cycle.
  always_comb begin
    stack_op_d  = StackNop;
    stack_w_d   = stack_w_q;
    pc_load_d   = 1'b0;
    pc_next_d   = pc_next_q;
    depth_d     = depth_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    busy_d      = busy_q;

    case (state_q)
      StIdle: begin
        if (accept) begin
          case (bus.cmd_op)
            OpCall: begin
              stack_op_d = StackPush;
              stack_w_d  = bus.cur_pc + WIDTH'(PC_STEP);
              pc_load_d  = 1'b1;
              pc_next_d  = bus.cmd_target;
              // A full stack still takes the push and drops its oldest entry.
              if (full) begin
                overflow_d = 1'b1;
              end else begin
                depth_d = depth_q + 1'b1;
              end
            end
            OpRet: begin
              pc_load_d = 1'b1;
              if (empty) begin
                pc_next_d   = TRAP_ADDR;
                underflow_d = 1'b1;
              end else begin
                pc_next_d  = bus.stack_a;
                stack_op_d = StackPop;
                depth_d    = depth_q - 1'b1;
              end
            end
            OpFlush: begin
              if (empty) begin
                overflow_d  = 1'b0;
                underflow_d = 1'b0;
              end else begin
                busy_d = 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
      StFlush: begin
        stack_op_d = StackPop;
        depth_d    = depth_q - 1'b1;
        if (last_pop) begin
          busy_d      = 1'b0;
          overflow_d  = 1'b0;
          underflow_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stack_op_q  <= StackNop;
      stack_w_q   <= '0;
      pc_load_q   <= 1'b0;
      pc_next_q   <= '0;
      depth_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      stack_op_q  <= stack_op_d;
      stack_w_q   <= stack_w_d;
      pc_load_q   <= pc_load_d;
      pc_next_q   <= pc_next_d;
      depth_q     <= depth_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.cmd_ready = cmd_ready;
  assign bus.stack_op  = stack_op_q;
  assign bus.stack_w   = stack_w_q;
  assign bus.pc_load   = pc_load_q;
  assign bus.pc_next   = pc_next_q;
  assign bus.depth     = depth_q;
  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_rs_call_sequencer.sv
// Randomized scoreboard bench for rs_call_sequencer with a negedge return-stack model.
module tb_rs_call_sequencer;

  localparam logic [1:0]  OpNop   = 2'b00;
  localparam logic [1:0]  OpCall  = 2'b01;
  localparam logic [1:0]  OpRet   = 2'b10;
  localparam logic [1:0]  OpFlush = 2'b11;
  localparam int          Depth   = 64;
  localparam logic [15:0] Trap    = 16'h0000;

  logic clk = 1'b0;
  logic reset = 1'b1;

  rs_call_sequencer_if #(.WIDTH(16), .DW(7)) bus ();

  rs_call_sequencer #(
    .DEPTH    (64),
    .WIDTH    (16),
    .DW       (7),
    .PC_STEP  (1),
    .TRAP_ADDR(16'h0000)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int pop_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, act, req, $time);
    end
  endtask

  // Attached return stack: applies the registered op on the negedge.
  logic [15:0] att[$];
  always @(negedge clk) begin
    if (reset) begin
      att.delete();
    end else if (bus.stack_op == 2'b01) begin
      if (att.size() == Depth) void'(att.pop_front());
      att.push_back(bus.stack_w);
    end else if (bus.stack_op == 2'b11 && att.size() > 0) begin
      void'(att.pop_back());
    end
    bus.stack_a = (att.size() > 0) ? att[$] : 16'h0000;
  end

  // Reference model: a list of return addresses plus sticky flags.
  typedef struct {
    logic [1:0]  op;
    logic [15:0] w;
    logic        pl;
    logic [15:0] pn;
    logic [6:0]  dep;
    logic        ovf;
    logic        unf;
    logic        busy;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] ref_stk[$];
  logic        ref_ovf;
  logic        ref_unf;
  logic [15:0] ref_w;

  task automatic ref_clear();
    ref_stk.delete();
    ref_ovf = 1'b0;
    ref_unf = 1'b0;
    ref_w   = 16'h0000;
  endtask

  task automatic ref_apply(input logic [1:0] op, input logic [15:0] tgt, input logic [15:0] pc);
    exp_t e;
    int   d;
    case (op)
      OpCall: begin
        ref_w = pc + 16'd1;
        if (ref_stk.size() == Depth) begin
          void'(ref_stk.pop_front());
          ref_ovf = 1'b1;
        end
        ref_stk.push_back(ref_w);
        e = '{2'b01, ref_w, 1'b1, tgt, 7'(ref_stk.size()), ref_ovf, ref_unf, 1'b0};
        exp_q.push_back(e);
      end
      OpRet: begin
        if (ref_stk.size() > 0) begin
          e.pn = ref_stk.pop_back();
          e = '{2'b11, ref_w, 1'b1, e.pn, 7'(ref_stk.size()), ref_ovf, ref_unf, 1'b0};
        end else begin
          ref_unf = 1'b1;
          e = '{2'b00, ref_w, 1'b1, Trap, 7'd0, ref_ovf, ref_unf, 1'b0};
        end
        exp_q.push_back(e);
      end
      OpFlush: begin
        d = ref_stk.size();
        for (int k = 1; k <= d; k++) begin
          e = '{2'b11, ref_w, 1'b0, 16'h0, 7'(d - k), (k < d) ? ref_ovf : 1'b0,
                (k < d) ? ref_unf : 1'b0, (k < d)};
          exp_q.push_back(e);
        end
        ref_stk.delete();
        ref_ovf = 1'b0;
        ref_unf = 1'b0;
      end
      default: ;
    endcase
  endtask

  // Monitor: every cycle with a redirect or stack op consumes one expected event.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (!reset && (bus.pc_load || bus.stack_op != 2'b00)) begin
      if (bus.stack_op == 2'b11) pop_cnt++;
      check("event_expected", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("stack_op", bus.stack_op, e.op);
        check("stack_w", bus.stack_w, e.w);
        check("pc_load", bus.pc_load, e.pl);
        if (e.pl) check("pc_next", bus.pc_next, e.pn);
        check("depth", bus.depth, e.dep);
        check("overflow", bus.overflow, e.ovf);
        check("underflow", bus.underflow, e.unf);
        check("busy", bus.busy, e.busy);
      end
    end
  end

  // Called at posedge+1; the command is accepted at the following posedge.
  task automatic issue(input logic [1:0] op, input logic [15:0] tgt, input logic [15:0] pc);
    int n = 0;
    while (!bus.cmd_ready && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!bus.cmd_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL ready_timeout: cmd_ready=0 after %0d cycles, expected 1", n);
      return;
    end
    bus.cmd_valid  = 1'b1;
    bus.cmd_op     = op;
    bus.cmd_target = tgt;
    bus.cur_pc     = pc;
    ref_apply(op, tgt, pc);
    @(posedge clk);
    #1;
    bus.cmd_valid  = 1'b0;
    bus.cmd_op     = 2'($urandom);
    bus.cmd_target = 16'($urandom);
    bus.cur_pc     = 16'($urandom);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int p0;
    int w;
    bus.cmd_valid  = 1'b0;
    bus.cmd_op     = OpNop;
    bus.cmd_target = 16'h0;
    bus.cur_pc     = 16'h0;
    ref_clear();

    // Reset state
    repeat (3) step();
    check("rst_depth", bus.depth, 0);
    check("rst_stack_op", bus.stack_op, 0);
    check("rst_pc_load", bus.pc_load, 0);
    check("rst_pc_next", bus.pc_next, 0);
    check("rst_stack_w", bus.stack_w, 0);
    check("rst_flags", {bus.overflow, bus.underflow, bus.busy}, 0);
    check("rst_ready_low", bus.cmd_ready, 0);
    reset = 1'b0;
    #1;
    check("ready_after_rst", bus.cmd_ready, 1);
    step();

    // Call then immediate return of the just-pushed address
    issue(OpCall, 16'h0200, 16'h0010);
    issue(OpRet, 16'h0, 16'h0);
    step();
    check("call_ret_depth", bus.depth, 0);
    check("call_ret_flags", {bus.overflow, bus.underflow}, 0);

    // Underflow, then a flush at depth 0 clears it in one cycle
    issue(OpRet, 16'h0, 16'h0);
    step();
    check("unf_sticky", bus.underflow, 1);
    issue(OpFlush, 16'h0, 16'h0);
    check("flush0_unf", bus.underflow, 0);
    check("flush0_ready", bus.cmd_ready, 1);

    // 65 calls saturate at 64, then 64 returns
    for (int i = 0; i <= 64; i++) issue(OpCall, 16'($urandom), 16'(i));
    step();
    check("sat_depth", bus.depth, 64);
    check("sat_ovf", bus.overflow, 1);
    for (int i = 0; i < 64; i++) issue(OpRet, 16'h0, 16'h0);
    issue(OpRet, 16'h0, 16'h0);
    step();
    check("flags_both", {bus.overflow, bus.underflow}, 2'b11);

    // Five calls then a flush: five busy cycles, five pops, flags cleared
    for (int i = 0; i < 5; i++) issue(OpCall, 16'($urandom), 16'($urandom));
    p0 = pop_cnt;
    issue(OpFlush, 16'h0, 16'h0);
    for (int k = 0; k < 5; k++) begin
      check("flush_busy", bus.busy, 1);
      check("flush_ready_low", bus.cmd_ready, 0);
      step();
    end
    check("flush_done_busy", bus.busy, 0);
    check("flush_done_ready", bus.cmd_ready, 1);
    check("flush_done_depth", bus.depth, 0);
    check("flush_done_flags", {bus.overflow, bus.underflow}, 0);
    step();
    check("flush_pop_count", pop_cnt - p0, 5);

    // Reset during the third pop cycle of a depth-10 flush
    for (int i = 0; i < 10; i++) issue(OpCall, 16'($urandom), 16'($urandom));
    issue(OpFlush, 16'h0, 16'h0);
    repeat (3) step();
    reset = 1'b1;
    step();
    check("rstflush_depth", bus.depth, 0);
    check("rstflush_stack_op", bus.stack_op, 0);
    check("rstflush_busy", bus.busy, 0);
    check("rstflush_pending", exp_q.size(), 7);
    exp_q.delete();
    ref_clear();
    reset = 1'b0;
    #1;
    check("rstflush_ready", bus.cmd_ready, 1);
    step();

    // Randomized mix
    for (int it = 0; it < 600; it++) begin
      w = $urandom_range(0, 99);
      if (w < 45) begin
        issue(OpCall, 16'($urandom), 16'($urandom));
      end else if (w < 85) begin
        issue(OpRet, 16'($urandom), 16'($urandom));
      end else if (w < 90) begin
        issue(OpFlush, 16'($urandom), 16'($urandom));
      end else begin
        bus.cmd_valid = 1'($urandom);
        bus.cmd_op    = OpNop;
        step();
        bus.cmd_valid = 1'b0;
      end
    end

    for (int n = 0; n < 200 && exp_q.size() > 0; n++) step();
    step();
    check("drain_empty", exp_q.size(), 0);
    check("final_depth", bus.depth, ref_stk.size());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rs_call_sequencer.md
Name: rs_call_sequencer

Overview:
- Drives the return stack from the control side: turns call, return and flush commands from the decode stage into stack push/pop operations, and turns them into PC redirects.
- Tracks stack occupancy and flags overflow/underflow.
- Runs on the posedge of the shared clock. The stack updates on the negedge, so a top-of-stack value changed by an op issued at posedge N is valid at posedge N+1.

Parameters:
- DEPTH, 64, entries in the attached return stack.
- WIDTH, 16, data/PC width.
- DW, 7, depth counter width; must satisfy 2^DW > DEPTH.
- PC_STEP, 1, return-address offset added to cur_pc on a call.
- TRAP_ADDR, 16'h0000, PC redirect target on underflow.

Ports:
- clk, input, 1, system clock; all state changes on posedge.
- reset, input, 1, synchronous, active-high.
- cmd_valid, input, 1, command present.
- cmd_op, input, 2, command code: 00 nop, 01 call, 10 ret, 11 flush.
- cmd_target, input, WIDTH, call destination.
- cur_pc, input, WIDTH, PC of the issuing instruction.
- cmd_ready, output, 1, sequencer can accept a command.
- pc_load, output, 1, one-cycle PC redirect strobe.
- pc_next, output, WIDTH, redirect value; valid while pc_load=1.
- stack_op, output, 2, to stack: 0 nop, 1 push, 3 pop; 2 is never driven.
- stack_w, output, WIDTH, push data to stack.
- stack_a, input, WIDTH, current top of stack.
- depth, output, DW, occupancy count.
- overflow, output, 1, sticky overflow flag.
- underflow, output, 1, sticky underflow flag.
- busy, output, 1, flush in progress.

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE.
  - stack_op=0, stack_w=0, pc_load=0, pc_next=0, depth=0, overflow=0, underflow=0, busy=0.
  - Reset mid-flush aborts immediately with no further pops.
- Registers: all outputs are registered. stack_op and pc_load are single-cycle pulses and default back to 0 every cycle unless re-asserted.
- Accept: a command is accepted at a posedge when cmd_valid=1, cmd_ready=1 and cmd_op!=00. cmd_op=00 is ignored.
- cmd_ready:
  - ready = (state==IDLE) and not reset.
  - Calls and returns are single-cycle, so back-to-back accepts every cycle are legal.
- CALL accepted at posedge N (outputs valid from N until N+1):
  - stack_op=1 and stack_w=(cur_pc+PC_STEP) mod 2^WIDTH.
  - pc_load=1 and pc_next=cmd_target.
  - If depth<DEPTH: depth+1.
  - If depth==DEPTH: push still issued (stack drops its oldest entry), depth stays DEPTH, overflow set.
- RET accepted at posedge N:
  - If depth>0: pc_next=stack_a as sampled at N, pc_load=1, stack_op=3, depth-1.
  - If depth==0: no pop, pc_load=1, pc_next=TRAP_ADDR, underflow set, depth stays 0.
  - RET immediately after CALL: the CALL's push lands on the intervening negedge, so RET at N+1 returns the just-pushed address.
- FLUSH accepted at posedge N:
  - If depth==0: completes in that same cycle (stays IDLE) and clears both flags; no pop.
  - Otherwise: state<=FLUSH, busy=1, cmd_ready=0.
- FLUSH state:
  - Each cycle: stack_op=3 and depth-1.
  - When depth reaches 0 (the cycle the last pop is issued): return to IDLE and clear busy, overflow and underflow.
  - Total pops = depth at accept; no pc_load during flush.
- Flags: overflow and underflow are sticky; cleared only by reset or a completed flush.
- stack_w: holds its last value when no push is issued.

Test Plan:
- Reset, then CALL cur_pc=0x0010 target=0x0200 -> one cycle of stack_op=1, stack_w=0x0011, pc_load=1, pc_next=0x0200; depth=1.
- CALL (cur_pc=0x0010) followed by RET on the next cycle, with a stack model on the negedge -> RET gives pc_next=0x0011, stack_op=3, depth=0, no flags.
- RET with depth=0 -> pc_load=1, pc_next=TRAP_ADDR, stack_op=0, underflow=1, depth=0.
- 65 consecutive CALLs (cur_pc=i) -> depth saturates at 64, overflow=1 from the 65th; 64 RETs then return 0x0041 down to 0x0002.
- 5 CALLs then FLUSH -> busy=1 and cmd_ready=0 for 5 cycles, exactly 5 pop pulses, then depth=0, flags cleared, cmd_ready=1.
- FLUSH with depth=10, reset asserted on the 3rd pop cycle -> next cycle state IDLE, depth=0, stack_op=0, busy=0.
